// File: rtl/decode_regfile_stage.sv
// Decode / operand-fetch stage: splits fetched instructions into fields,
// reads rs1/rs2 from a 32x32 register file (x0 = 0) with writeback bypass,
// and holds the result in a single output register toward the ALU.
module decode_regfile_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [6:0]      ex_opcode,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic [11:0]     ex_imm,
  output logic [19:0]     ex_uimm,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [XLEN-1:0] regs [NREGS];
  // Source indices of the held instruction, kept so stalled operands can be refreshed.
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;

  logic [6:0]      d_opcode;
  logic            d_is_r;
  logic            d_is_i;
  logic            d_is_u;
  logic            d_legal;
  logic [AW-1:0]   d_rs1;
  logic [AW-1:0]   d_rs2;
  logic [AW-1:0]   d_rd;
  logic [6:0]      d_funct7;
  logic [2:0]      d_funct3;
  logic [11:0]     d_imm;
  logic [19:0]     d_uimm;
  logic [XLEN-1:0] d_rs1_val;
  logic [XLEN-1:0] d_rs2_val;
  logic            wb_hit;
  logic            accept;
  logic            stall;

  assign if_ready = !ex_valid || ex_ready;
  assign accept   = if_valid && if_ready;
  assign stall    = ex_valid && !ex_ready;
  assign wb_hit   = wb_en && (wb_rd != '0);

  assign d_opcode = if_instr[6:0];
  assign d_rd     = if_instr[7 +: AW];
  assign d_rs1    = if_instr[15 +: AW];
  assign d_rs2    = if_instr[20 +: AW];

  // Field extraction and operand read with same-cycle writeback bypass.
  always_comb begin
    d_is_r    = (d_opcode == OP_R);
    d_is_i    = (d_opcode == OP_I);
    d_is_u    = (d_opcode == OP_LUI) || (d_opcode == OP_AUIPC);
    d_legal   = d_is_r || d_is_i || d_is_u;
    d_funct7  = d_is_u ? 7'd0 : if_instr[31:25];
    d_funct3  = d_is_u ? 3'd0 : if_instr[14:12];
    d_imm     = (d_is_i || d_is_u) ? if_instr[31:20] : 12'd0;
    d_uimm    = d_is_u ? if_instr[31:12] : 20'd0;
    d_rs1_val = '0;
    d_rs2_val = '0;
    if (d_rs1 != '0) begin
      d_rs1_val = (wb_hit && (wb_rd == d_rs1)) ? wb_data : regs[d_rs1];
    end
    if (d_is_r && (d_rs2 != '0)) begin
      d_rs2_val = (wb_hit && (wb_rd == d_rs2)) ? wb_data : regs[d_rs2];
    end
  end

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Output pipeline register: flush beats accept; a stalled entry tracks writebacks to its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct7    <= '0;
      ex_funct3    <= '0;
      ex_imm       <= '0;
      ex_uimm      <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_opcode    <= d_opcode;
      ex_funct7    <= d_funct7;
      ex_funct3    <= d_funct3;
      ex_imm       <= d_imm;
      ex_uimm      <= d_uimm;
      ex_rs1_val   <= d_rs1_val;
      ex_rs2_val   <= d_rs2_val;
      ex_rd        <= d_rd;
      ex_reg_write <= d_legal && (d_rd != '0);
      ex_illegal   <= !d_legal;
      rs1_q        <= d_rs1;
      rs2_q        <= d_rs2;
    end else if (stall) begin
      if (wb_hit && (wb_rd == rs1_q)) begin
        ex_rs1_val <= wb_data;
      end
      if (wb_hit && (wb_rd == rs2_q) && (ex_opcode == OP_R)) begin
        ex_rs2_val <= wb_data;
      end
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Randomized and directed bench for decode_regfile_stage against a
// field-level reference model of decode, register file and handshake.
module tb_decode_regfile_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [19:0] uimm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_imm;
  logic [19:0] ex_uimm;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_illegal;

  fields_t obs;
  assign obs = {ex_opcode, ex_funct7, ex_funct3, ex_imm, ex_uimm, ex_rs1_val,
                ex_rs2_val, ex_rd, ex_reg_write, ex_illegal};

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mregs [32];
  logic        m_valid;
  fields_t     m_f;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;

  decode_regfile_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .ex_imm(ex_imm), .ex_uimm(ex_uimm), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic fields_t mk(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [11:0] imm, input logic [19:0] uimm,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] rd, input logic rw, input logic ill);
    return {op, f7, f3, imm, uimm, r1, r2, rd, rw, ill};
  endfunction

  // Register read as seen in the accept cycle, including the writeback bypass.
  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic fields_t ref_decode(input logic [31:0] ins);
    fields_t f;
    f = '0;
    f.opcode = ins[6:0];
    f.rd     = ins[11:7];
    f.rs1    = read_reg(ins[19:15]);
    case (ins[6:0])
      7'b0110011: begin
        f.funct7 = ins[31:25];
        f.funct3 = ins[14:12];
        f.rs2    = read_reg(ins[24:20]);
      end
      7'b0010011: begin
        f.funct7 = ins[31:25];
        f.funct3 = ins[14:12];
        f.imm    = ins[31:20];
      end
      7'b0110111, 7'b0010111: begin
        f.imm  = ins[31:20];
        f.uimm = ins[31:12];
      end
      default: begin
        f.funct7  = ins[31:25];
        f.funct3  = ins[14:12];
        f.illegal = 1'b1;
      end
    endcase
    f.reg_write = !f.illegal && (ins[11:7] != 5'd0);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_valid = 1'b0;
    m_f     = '0;
    m_rs1   = '0;
    m_rs2   = '0;
  endtask

  task automatic model_step();
    logic rdy;
    rdy = !m_valid || ex_ready;
    if (flush) begin
      m_valid = 1'b0;
    end else if (if_valid && rdy) begin
      m_valid = 1'b1;
      m_f     = ref_decode(if_instr);
      m_rs1   = if_instr[19:15];
      m_rs2   = if_instr[24:20];
    end else if (m_valid && !ex_ready) begin
      if (wb_en && wb_rd != 0 && wb_rd == m_rs1) m_f.rs1 = wb_data;
      if (wb_en && wb_rd != 0 && wb_rd == m_rs2 && m_f.opcode == 7'b0110011) m_f.rs2 = wb_data;
    end else begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
  endtask

  // One clock: inputs already driven; check if_ready, advance model, compare after edge.
  task automatic cycle();
    #1;
    check("if_ready", 128'(if_ready), 128'(!m_valid || ex_ready));
    model_step();
    @(posedge clk);
    #1;
    check("ex_valid", 128'(ex_valid), 128'(m_valid));
    if (m_valid) check("fields", 128'(obs), 128'(m_f));
  endtask

  task automatic set_idle();
    if_valid = 1'b0;
    if_instr = '0;
    flush    = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    ex_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [5];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0110111; ops[3] = 7'b0010111;

    // Reset state
    set_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(ex_valid), 128'(0));
    check("rst_fields", 128'(obs), 128'(0));
    check("rst_if_ready", 128'(if_ready), 128'(1));
    rst_n = 1'b1;

    // x5=7, x6=3, then ADD x7,x5,x6
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h7; cycle();
    wb_rd = 5'd6; wb_data = 32'h3; cycle();
    wb_en = 1'b0; if_valid = 1'b1; if_instr = 32'h006283B3; cycle();
    check("add_valid", 128'(ex_valid), 128'(1));
    check("add_fields", 128'(obs), 128'(mk(7'h33, 7'h0, 3'h0, 12'h0, 20'h0, 32'h7, 32'h3, 5'd7, 1'b1, 1'b0)));

    // ADDI x1,x0,-1 with a same-cycle write to x0
    if_instr = 32'hFFF00093; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD; cycle();
    check("addi_fields", 128'(obs), 128'(mk(7'h13, 7'h7F, 3'h0, 12'hFFF, 20'h0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0)));

    // SUB x3,x1,x2 held under stall while x1 is written
    wb_en = 1'b0; if_instr = 32'h402081B3; cycle();
    ex_ready = 1'b0; if_instr = 32'h0094E233; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    #1;
    check("stall_if_ready", 128'(if_ready), 128'(0));
    cycle();
    check("stall_refresh", 128'(obs), 128'(mk(7'h33, 7'h20, 3'h0, 12'h0, 20'h0, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0)));
    check("stall_valid", 128'(ex_valid), 128'(1));
    ex_ready = 1'b1; if_valid = 1'b0; wb_en = 1'b0; cycle();
    check("drain_valid", 128'(ex_valid), 128'(0));

    // OR x4,x9,x9 with double bypass
    if_valid = 1'b1; if_instr = 32'h0094E233; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_A5A5; cycle();
    check("or_bypass", 128'(obs), 128'(mk(7'h33, 7'h0, 3'h6, 12'h0, 20'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd4, 1'b1, 1'b0)));

    // LUI and an unsupported opcode
    wb_en = 1'b0; if_instr = 32'h12345137; cycle();
    check("lui_fields", 128'(obs), 128'(mk(7'h37, 7'h0, 3'h0, 12'h123, 20'h12345, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0)));
    if_instr = 32'h000000EF; cycle();
    check("illegal_flags", 128'({ex_valid, ex_illegal, ex_reg_write}), 128'(3'b110));

    // Flush beats accept
    if_instr = 32'h006283B3; flush = 1'b1; cycle();
    check("flush_valid", 128'(ex_valid), 128'(0));
    flush = 1'b0;

    // Async reset during a stall
    cycle();
    ex_ready = 1'b0; if_valid = 1'b0; cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(ex_valid), 128'(0));
    check("arst_fields", 128'(obs), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_idle();
    if_valid = 1'b1; if_instr = 32'h006283B3; cycle();
    check("post_rst_x5", 128'(ex_rs1_val), 128'(0));
    check("post_rst_x6", 128'(ex_rs2_val), 128'(0));

    // Randomized traffic; small index range makes bypass/refresh collisions frequent
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      ops[4] = r[6:0];
      if_instr = $urandom;
      if_instr[6:0]   = ops[$urandom_range(0, 4)];
      if_instr[19:15] = 5'($urandom_range(0, 7));
      if_instr[24:20] = 5'($urandom_range(0, 7));
      if_valid = ($urandom_range(0, 9) < 7);
      ex_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 19) == 0);
      wb_en    = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_regfile_stage.md
Name: decode_regfile_stage

Overview:
- Decode/operand-fetch stage directly upstream of the integer ALU.
- Accepts 32-bit instructions from fetch over a valid/ready handshake.
- Splits each instruction into opcode/funct7/funct3/imm fields and reads rs1/rs2 from an internal 32x32 register file.
- Presents the result to the ALU through one output pipeline register; the writeback port writes the register file.

Parameters:
- XLEN, 32, data width of registers and operands
- NREGS, 32, number of architectural registers (x0 hardwired to zero)
- AW, 5, register index width (log2 NREGS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_ready  out  1  stage can accept an instruction this cycle
- flush  in  1  synchronous kill of the held output instruction
- wb_en  in  1  register-file write enable
- wb_rd  in  AW  write index
- wb_data  in  XLEN  write data
- ex_ready  in  1  ALU stage accepts the output
- ex_valid  out  1  output register holds a valid instruction
- ex_opcode  out  7  instr[6:0]
- ex_funct7  out  7  instr[31:25]; forced to 0 for U-type
- ex_funct3  out  3  instr[14:12]; forced to 0 for U-type
- ex_imm  out  12  instr[31:20] for I-type and U-type; 0 for R-type
- ex_uimm  out  20  instr[31:12] for U-type; 0 otherwise
- ex_rs1_val  out  XLEN  rs1 operand
- ex_rs2_val  out  XLEN  rs2 operand; 0 for non-R-type
- ex_rd  out  AW  instr[11:7]
- ex_reg_write  out  1  instruction writes rd
- ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* outputs go to 0, including ex_valid=0.
  - All registers x0..x31 clear to 0.
  - Internal rs1/rs2 index copies clear to 0.
  - Reset mid-stall discards the held instruction.
- Supported opcodes: 0110011 (R), 0010011 (I), 0110111 (LUI), 0010111 (AUIPC).
  - Any other opcode: ex_illegal=1, ex_reg_write=0. The instruction still flows through the handshake.
- ex_reg_write = legal opcode AND instr[11:7]!=0.
- Handshake:
  - if_ready = !ex_valid || ex_ready (combinational).
  - Accept = if_valid && if_ready. On accept, the output register loads all decoded fields and operands next edge, and ex_valid=1. Latency is 1 cycle.
  - If not accepting and ex_ready=1: ex_valid clears to 0.
  - If ex_valid=1 and ex_ready=0: all ex_* outputs hold stable.
  - flush=1: ex_valid=0 next edge. Flush has priority over accept; if_ready is unaffected by flush and the instruction is dropped.
- Register file:
  - Write at rising edge when wb_en=1 and wb_rd!=0. Writes to x0 are ignored; x0 always reads 0.
  - Read bypass: if wb_en=1 and wb_rd equals the source index (nonzero) in the accept cycle, the operand takes wb_data, not the stale array value.
  - Both rs1 and rs2 may bypass simultaneously when rs1==rs2.
- Stall refresh: while ex_valid=1 and ex_ready=0, a write (wb_en, wb_rd!=0) matching the held rs1 index updates ex_rs1_val to wb_data next edge. Same rule applies to rs2 (R-type only). Other ex_* fields remain unchanged.
- No arithmetic in this stage. Immediates are raw fields with no sign extension.

Test Plan:
- Reset, then x5 via wb (wb_rd=5, wb_data=32'h0000_0007) and x6=32'h0000_0003; issue ADD x7,x5,x6 (32'h006283B3) with ex_ready=1 -> one cycle later ex_valid=1, opcode=0110011, funct3=000, funct7=0, rs1_val=7, rs2_val=3, rd=7, reg_write=1, imm=0.
- Issue ADDI x1,x0,-1 (32'hFFF00093) -> ex_imm=12'hFFF, rs1_val=0, rs2_val=0, funct7=7'h7F, reg_write=1; same cycle wb to x0 with 32'hDEAD -> x0 still reads 0.
- Hold ex_ready=0 with SUB x3,x1,x2 held; assert wb_en, wb_rd=1, wb_data=32'h55 -> if_ready=0, ex_rs1_val becomes 32'h55 next edge, all other outputs unchanged; release ex_ready -> ex_valid drops the following cycle if if_valid=0.
- Issue OR x4,x9,x9 in the same cycle as wb_en, wb_rd=9, wb_data=32'hA5A5_A5A5 -> ex_rs1_val = ex_rs2_val = 32'hA5A5_A5A5.
- LUI x2,0x12345 (32'h12345137) -> ex_uimm=20'h12345, ex_imm=12'h123, funct3=0, funct7=0; opcode 1101111 -> ex_illegal=1, ex_reg_write=0, ex_valid=1.
- Assert flush together with a valid accept -> ex_valid=0 next cycle. Pull rst_n low mid-stall -> ex_valid and all outputs 0 immediately; after release, a read of x5 returns 0.
